// File: rtl/ifetch_pkg.sv
// ifetch_pkg: shared constants and types for the instruction fetch controller.
//   IFQ_DEPTH       - entries in the fetch return queue
//   IFQ_CNT_W       - width of the queue occupancy count (holds 0..IFQ_DEPTH)
//   IFETCH_RESET_PC - default fetch PC after reset
//   fetch_entry_t   - {pc, data} pair for the default 32-bit configuration
package ifetch_pkg;

  localparam int          IFQ_DEPTH       = 2;
  localparam int          IFQ_CNT_W       = $clog2(IFQ_DEPTH + 1);
  localparam logic [31:0] IFETCH_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
  } fetch_entry_t;

endpackage

// File: rtl/ifetch_queue.sv
// ifetch_queue: 2-entry FIFO of {pc, data} returned by instruction memory.
// Slot 0 is always the head, so head outputs come straight from flops.
// Ports:
//   clk, rst              - clock, asynchronous active-high reset
//   push, push_pc/data    - write an entry (never while full)
//   pop                   - drop the head (only while count != 0)
//   flush                 - empty the queue; wins over push/pop
//   count                 - occupancy 0..2
//   head_valid/pc/data    - head entry
module ifetch_queue
  import ifetch_pkg::*;
#(
  parameter int WIDTH_ADDR = 32,
  parameter int WIDTH_DATA = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [WIDTH_ADDR-1:0] push_pc,
  input  logic [WIDTH_DATA-1:0] push_data,
  input  logic                  pop,
  input  logic                  flush,
  output logic [IFQ_CNT_W-1:0]  count,
  output logic                  head_valid,
  output logic [WIDTH_ADDR-1:0] head_pc,
  output logic [WIDTH_DATA-1:0] head_data
);

  logic [WIDTH_ADDR-1:0] pc0_q, pc1_q;
  logic [WIDTH_DATA-1:0] d0_q, d1_q;
  logic [IFQ_CNT_W-1:0]  cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc0_q <= '0;
      d0_q  <= '0;
      pc1_q <= '0;
      d1_q  <= '0;
      cnt_q <= '0;
    end else if (flush) begin
      cnt_q <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (cnt_q == '0) begin
            pc0_q <= push_pc;
            d0_q  <= push_data;
          end else begin
            pc1_q <= push_pc;
            d1_q  <= push_data;
          end
          cnt_q <= cnt_q + 1'b1;
        end
        2'b01: begin
          // Shift slot 1 forward; harmless stale copy when count was 1.
          pc0_q <= pc1_q;
          d0_q  <= d1_q;
          cnt_q <= cnt_q - 1'b1;
        end
        2'b11: begin
          // Count is unchanged. With one entry the new word becomes head.
          if (cnt_q == IFQ_CNT_W'(1)) begin
            pc0_q <= push_pc;
            d0_q  <= push_data;
          end else begin
            pc0_q <= pc1_q;
            d0_q  <= d1_q;
            pc1_q <= push_pc;
            d1_q  <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign count      = cnt_q;
  assign head_valid = (cnt_q != '0);
  assign head_pc    = pc0_q;
  assign head_data  = d0_q;

endmodule

// File: rtl/ifetch_ctrl.sv
// ifetch_ctrl: instruction fetch controller for a 1-cycle synchronous ROM.
// Owns the fetch PC, issues one read per cycle when the return path has room,
// buffers returned words in ifetch_queue and hands them to decode.
// Optional build macro: IFETCH_PERF_EN enables the two performance counters;
// without it the perf ports read 0 and no counter flops exist.
// Ports:
//   clk, rst                   - clock, asynchronous active-high reset
//   fetch_en                   - permits new reads
//   redirect_valid/redirect_pc - flush and restart at a new PC
//   mem_addr, mem_rdata        - ROM word address / data one cycle later
//   inst_valid/ready/data/pc   - decode handshake and head instruction
//   perf_fetch_cnt             - accepted instructions
//   perf_stall_cnt             - cycles with fetch_en=1 and nothing to offer
module ifetch_ctrl
  import ifetch_pkg::*;
#(
  parameter int                    WIDTH_ADDR = 32,
  parameter int                    WIDTH_DATA = 32,
  parameter logic [WIDTH_ADDR-1:0] RESET_PC   = WIDTH_ADDR'(IFETCH_RESET_PC)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fetch_en,
  input  logic                  redirect_valid,
  input  logic [WIDTH_ADDR-1:0] redirect_pc,
  output logic [WIDTH_ADDR-1:0] mem_addr,
  input  logic [WIDTH_DATA-1:0] mem_rdata,
  output logic                  inst_valid,
  input  logic                  inst_ready,
  output logic [WIDTH_DATA-1:0] inst_data,
  output logic [WIDTH_ADDR-1:0] inst_pc,
  output logic [31:0]           perf_fetch_cnt,
  output logic [31:0]           perf_stall_cnt
);

  logic [WIDTH_ADDR-1:0] pc_q, inflight_pc_q;
  logic                  inflight_q;
  logic [IFQ_CNT_W-1:0]  count;
  logic [IFQ_CNT_W:0]    occ;
  logic                  pop, push, issue;

  assign pop  = inst_valid & inst_ready;
  assign push = inflight_q & ~redirect_valid;

  // Occupancy after this cycle's pop, counting the word still in flight.
  // A new read only goes out if its word is guaranteed a slot.
  assign occ   = {1'b0, count} + {{IFQ_CNT_W{1'b0}}, inflight_q}
               - {{IFQ_CNT_W{1'b0}}, pop};
  assign issue = fetch_en & ~redirect_valid & (occ <= (IFQ_CNT_W+1)'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
    end else if (redirect_valid) begin
      pc_q       <= redirect_pc & ~WIDTH_ADDR'(3);
      inflight_q <= 1'b0;
    end else if (issue) begin
      inflight_q    <= 1'b1;
      inflight_pc_q <= pc_q;
      pc_q          <= pc_q + WIDTH_ADDR'(4);
    end else begin
      inflight_q <= 1'b0;
    end
  end

  assign mem_addr = pc_q >> 2;

  ifetch_queue #(
    .WIDTH_ADDR (WIDTH_ADDR),
    .WIDTH_DATA (WIDTH_DATA)
  ) u_queue (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_pc    (inflight_pc_q),
    .push_data  (mem_rdata),
    .pop        (pop),
    .flush      (redirect_valid),
    .count      (count),
    .head_valid (inst_valid),
    .head_pc    (inst_pc),
    .head_data  (inst_data)
  );

`ifdef IFETCH_PERF_EN
  logic [31:0] fetch_cnt_q, stall_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (pop)                    fetch_cnt_q <= fetch_cnt_q + 32'd1;
      if (fetch_en & ~inst_valid) stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign perf_fetch_cnt = fetch_cnt_q;
  assign perf_stall_cnt = stall_cnt_q;
`else
  assign perf_fetch_cnt = 32'd0;
  assign perf_stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_ifetch_ctrl.sv
// tb_ifetch_ctrl: scoreboard bench for ifetch_ctrl. A behavioural ROM returns
// 32'h1000_0000 + word address; expected {pc, data} pairs are queued as each
// phase is set up and compared as decode accepts instructions.
module tb_ifetch_ctrl;
  import ifetch_pkg::*;

  logic        clk, rst, fetch_en, redirect_valid, inst_valid, inst_ready;
  logic [31:0] redirect_pc, mem_addr, mem_rdata, inst_data, inst_pc;
  logic [31:0] perf_fetch_cnt, perf_stall_cnt;

  int n_chk = 0, n_err = 0, pop_cnt = 0, n_pushed = 0;
  fetch_entry_t sb[$];

  ifetch_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .fetch_en       (fetch_en),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .mem_addr       (mem_addr),
    .mem_rdata      (mem_rdata),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc),
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_stall_cnt (perf_stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 1-cycle synchronous ROM
  always @(posedge clk) mem_rdata <= 32'h1000_0000 + mem_addr;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  task automatic expect_seq(input logic [31:0] start_pc, input int n);
    fetch_entry_t e;
    logic [31:0] pc;
    pc = start_pc;
    for (int i = 0; i < n; i++) begin
      e.pc   = pc;
      e.data = 32'h1000_0000 + (pc >> 2);
      sb.push_back(e);
      n_pushed++;
      pc = pc + 32'd4;
    end
  endtask

  // Returns at posedge+1 of the edge that committed the target-th accept.
  task automatic wait_pops(input int target);
    int n = 0;
    while (pop_cnt < target && n < 300) begin
      @(posedge clk);
      n++;
    end
    #1;
    if (pop_cnt < target) chk("pop_timeout", pop_cnt, target);
  endtask

  // Scoreboard consumer: every accept must match the next expected entry.
  always @(negedge clk) begin
    fetch_entry_t e;
    if (!rst && inst_valid && inst_ready) begin
      pop_cnt++;
      if (sb.size() == 0) begin
        chk("extra_pop", pop_cnt, n_pushed);
      end else begin
        e = sb.pop_front();
        chk("sb_pc", inst_pc, e.pc);
        chk("sb_data", inst_data, e.data);
      end
    end
  end

  initial begin
    rst = 1'b1; fetch_en = 1'b1; inst_ready = 1'b1;
    redirect_valid = 1'b0; redirect_pc = '0;
    #1;
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_valid", {31'd0, inst_valid}, 32'd0);
    chk("rst_data", inst_data, 32'h0);
    chk("rst_pc", inst_pc, 32'h0);
    chk("rst_perf_fetch", perf_fetch_cnt, 32'd0);
    chk("rst_perf_stall", perf_stall_cnt, 32'd0);
    @(posedge clk); @(posedge clk); #1;

    // Startup latency: valid first in cycle 2 after reset release.
    expect_seq(32'h0, 2);
    rst = 1'b0;
    @(negedge clk); chk("c0_valid", {31'd0, inst_valid}, 32'd0);
    @(negedge clk); chk("c1_valid", {31'd0, inst_valid}, 32'd0);
    @(negedge clk); chk("c2_valid", {31'd0, inst_valid}, 32'd1);
    chk("c2_pc", inst_pc, 32'h0);

    // Backpressure: after two accepts, stall 5 cycles; queue fills, pc_q=0x10.
    wait_pops(2);
    inst_ready = 1'b0;
    repeat (5) @(negedge clk);
    chk("stall_valid", {31'd0, inst_valid}, 32'd1);
    chk("stall_head_pc", inst_pc, 32'h8);
    chk("stall_mem_addr", mem_addr, 32'h4);
    expect_seq(32'h8, 4);
    @(posedge clk); #1;
    inst_ready = 1'b1;
    wait_pops(6);
    inst_ready = 1'b0;

    // Redirect while full: bubbles at T+1, T+2, redirected head at T+3.
    repeat (3) @(posedge clk); #1;
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0102;
    expect_seq(32'h100, 6);
    @(posedge clk); #1;
    redirect_valid = 1'b0; inst_ready = 1'b1;
    @(negedge clk); chk("rd_t1_valid", {31'd0, inst_valid}, 32'd0);
    @(negedge clk); chk("rd_t2_valid", {31'd0, inst_valid}, 32'd0);
    @(negedge clk); chk("rd_t3_valid", {31'd0, inst_valid}, 32'd1);
    chk("rd_t3_pc", inst_pc, 32'h100);
    chk("rd_t3_data", inst_data, 32'h1000_0040);

    // fetch_en low 4 cycles: in-flight word still lands, then queue runs dry.
    @(posedge clk); #1;
    @(posedge clk); #1;
    fetch_en = 1'b0;
    repeat (3) @(negedge clk);
    chk("fen_drain1", {31'd0, inst_valid}, 32'd0);
    @(negedge clk);
    chk("fen_drain2", {31'd0, inst_valid}, 32'd0);
    @(posedge clk); #1;
    fetch_en = 1'b1;
    wait_pops(12);
    inst_ready = 1'b0;

    // PC wrap at the top of the address space.
    repeat (3) @(posedge clk); #1;
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    expect_seq(32'hFFFF_FFFC, 3);
    @(posedge clk); #1;
    redirect_valid = 1'b0; inst_ready = 1'b1;
    wait_pops(15);
    inst_ready = 1'b0;

    // Asynchronous reset mid-operation, no clock edge needed.
    repeat (3) @(posedge clk); #1;
    rst = 1'b1;
    #2;
    chk("arst_valid", {31'd0, inst_valid}, 32'd0);
    chk("arst_mem_addr", mem_addr, 32'h0);
    chk("arst_pc", inst_pc, 32'h0);
    chk("arst_data", inst_data, 32'h0);

    // Perf: redirect in cycle 0 gives 3 starved cycles, then 10 accepts.
    @(posedge clk); #1;
    rst = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h0;
    inst_ready = 1'b1; fetch_en = 1'b1;
    expect_seq(32'h0, 10);
    @(posedge clk); #1;
    redirect_valid = 1'b0;
    wait_pops(25);
    inst_ready = 1'b0;
    repeat (3) @(negedge clk);
`ifdef IFETCH_PERF_EN
    chk("perf_fetch", perf_fetch_cnt, 32'd10);
    chk("perf_stall", perf_stall_cnt, 32'd3);
`else
    chk("perf_fetch_off", perf_fetch_cnt, 32'd0);
    chk("perf_stall_off", perf_stall_cnt, 32'd0);
`endif
    chk("sb_drained", sb.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
